// File: rtl/qpu_dtcm_mp_ctrl_pkg.sv
// Shared defaults and helpers for the multi-port DTCM controller slice.
package qpu_dtcm_mp_ctrl_pkg;

    localparam int QPU_DTCM_NPORT = 2;
    localparam int QPU_DTCM_DW    = 32;
    localparam int QPU_DTCM_AW    = 16;
    localparam int QPU_DTCM_DEPTH = 4096;
    localparam int QPU_DTCM_MW    = QPU_DTCM_DW / 8;

    // Pointer width for a port index; a single port still needs a 1-bit register.
    function automatic int qpu_dtcm_ptr_w(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

endpackage

// File: rtl/qpu_dtcm_mp_ctrl_if.sv
// Bundled multi-port ICB command/response channels seen by the DTCM controller.
interface qpu_dtcm_mp_ctrl_if #(
    parameter int NPORT = 2,
    parameter int DW    = 32,
    parameter int AW    = 16
);
    localparam int MW = DW / 8;

    logic [NPORT-1:0]    cmd_valid;
    logic [NPORT-1:0]    cmd_ready;
    logic [NPORT*AW-1:0] cmd_addr;
    logic [NPORT-1:0]    cmd_read;
    logic [NPORT*DW-1:0] cmd_wdata;
    logic [NPORT*MW-1:0] cmd_wmask;
    logic [NPORT-1:0]    rsp_valid;
    logic [NPORT-1:0]    rsp_ready;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/qpu_dtcm_mp_ctrl_arb.sv
// Parametric fixed-priority / round-robin arbiter; owns the last-granted pointer.
module qpu_dtcm_arb
    import qpu_dtcm_mp_ctrl_pkg::*;
#(
    parameter int NPORT  = QPU_DTCM_NPORT,
    parameter int ARB_RR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             advance,
    output logic [NPORT-1:0] grant
);
    localparam int PW = qpu_dtcm_ptr_w(NPORT);

    logic [PW-1:0] last_granted;
    logic [PW-1:0] grant_idx;

    // Scan order starts one past the last winner in RR mode, at port 0 otherwise.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            idx = (ARB_RR != 0) ? ((int'(last_granted) + 1 + i) % NPORT) : i;
            for (int p = 0; p < NPORT; p++) begin
                if (!found && (p == idx) && req[p]) begin
                    grant[p]  = 1'b1;
                    grant_idx = PW'(p);
                    found     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_granted <= PW'(NPORT - 1);
        end else if (advance) begin
            last_granted <= grant_idx;
        end
    end

endmodule

// File: rtl/qpu_dtcm_mp_ctrl.sv
// Multi-port DTCM controller: arbitrates NPORT ICB masters onto one 1-cycle-latency SRAM.
module qpu_dtcm_mp_ctrl
    import qpu_dtcm_mp_ctrl_pkg::*;
#(
    parameter int NPORT  = QPU_DTCM_NPORT,
    parameter int DW     = QPU_DTCM_DW,
    parameter int AW     = QPU_DTCM_AW,
    parameter int DEPTH  = QPU_DTCM_DEPTH,
    parameter int ARB_RR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tcm_cgstop,
    input  logic                     test_mode,
    qpu_dtcm_mp_ctrl_if.slave        icb,
    output logic                     dtcm_ram_cs,
    output logic                     dtcm_ram_we,
    output logic [$clog2(DEPTH)-1:0] dtcm_ram_addr,
    output logic [DW/8-1:0]          dtcm_ram_wem,
    output logic [DW-1:0]            dtcm_ram_din,
    input  logic [DW-1:0]            dtcm_ram_dout,
    output logic                     clk_dtcm_ram,
    output logic                     dtcm_active
);
    localparam int MW     = DW / 8;
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int OFF    = $clog2(MW);

    logic [NPORT-1:0] grant_p0;
    logic             rsp_hs, stage_free, cmd_hs_p0, in_range_p0;
    logic [AW-1:0]    sel_addr_p0, sel_word_p0;
    logic             sel_read_p0;
    logic [DW-1:0]    sel_wdata_p0;
    logic [MW-1:0]    sel_wmask_p0;

    logic             vld_p1, captured_p1, read_p1, err_p1;
    logic [NPORT-1:0] port_oh_p1;
    logic [DW-1:0]    hold_data_p1;
    logic             gate_en, gate_en_lat;

    qpu_dtcm_arb #(.NPORT(NPORT), .ARB_RR(ARB_RR)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (icb.cmd_valid),
        .advance (cmd_hs_p0),
        .grant   (grant_p0)
    );

    // ---- p0: accept cycle, drive the RAM combinationally ----
    assign rsp_hs        = vld_p1 & |(port_oh_p1 & icb.rsp_ready);
    assign stage_free    = !rst & (!vld_p1 | rsp_hs);
    assign icb.cmd_ready = stage_free ? grant_p0 : '0;
    assign cmd_hs_p0     = stage_free & |grant_p0;

    always_comb begin
        sel_addr_p0  = '0;
        sel_read_p0  = 1'b0;
        sel_wdata_p0 = '0;
        sel_wmask_p0 = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant_p0[p]) begin
                sel_addr_p0  = icb.cmd_addr[p*AW +: AW];
                sel_read_p0  = icb.cmd_read[p];
                sel_wdata_p0 = icb.cmd_wdata[p*DW +: DW];
                sel_wmask_p0 = icb.cmd_wmask[p*MW +: MW];
            end
        end
    end

    assign sel_word_p0   = sel_addr_p0 >> OFF;
    assign in_range_p0   = (32'(sel_word_p0) < 32'(DEPTH));
    assign dtcm_ram_cs   = cmd_hs_p0 & in_range_p0;
    assign dtcm_ram_we   = dtcm_ram_cs & !sel_read_p0;
    assign dtcm_ram_addr = sel_addr_p0[OFF +: RAM_AW];
    assign dtcm_ram_wem  = dtcm_ram_we ? sel_wmask_p0 : '0;
    assign dtcm_ram_din  = sel_wdata_p0;

    // ---- p1: single-entry response stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            captured_p1 <= 1'b0;
        end else if (cmd_hs_p0) begin
            vld_p1      <= 1'b1;
            captured_p1 <= 1'b0;
        end else if (rsp_hs) begin
            vld_p1      <= 1'b0;
        end else if (vld_p1 && read_p1 && !err_p1) begin
            captured_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs_p0) begin
            port_oh_p1 <= grant_p0;
            read_p1    <= sel_read_p0;
            err_p1     <= !in_range_p0;
        end
        // RAM dout is only valid for one cycle; keep it while the master stalls.
        if (vld_p1 && read_p1 && !err_p1 && !captured_p1 && !rsp_hs) begin
            hold_data_p1 <= dtcm_ram_dout;
        end
    end

    assign icb.rsp_valid = vld_p1 ? port_oh_p1 : '0;
    assign icb.rsp_err   = vld_p1 & err_p1;
    assign icb.rsp_rdata = (vld_p1 && read_p1 && !err_p1)
                         ? (captured_p1 ? hold_data_p1 : dtcm_ram_dout) : '0;

    assign dtcm_active = |icb.cmd_valid | vld_p1;

    // Latch-based ICG; enable also covers the uncaptured read-response cycle.
    assign gate_en = dtcm_ram_cs | tcm_cgstop | test_mode
                   | (vld_p1 & read_p1 & !err_p1 & !captured_p1);

    always_latch begin
        if (!clk) gate_en_lat = gate_en;
    end

    assign clk_dtcm_ram = clk & gate_en_lat;

endmodule

// File: tb/tb_qpu_dtcm_mp_ctrl.sv
// Directed bench: one round-robin instance with a RAM model, one fixed-priority instance.
module tb_qpu_dtcm_mp_ctrl;
    localparam int NPORT = 2;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4096;
    localparam int MW    = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tcm_cgstop = 1'b0;
    logic test_mode  = 1'b0;
    always #5 clk = ~clk;

    int nasrt = 0;
    int nfail = 0;

    qpu_dtcm_mp_ctrl_if #(.NPORT(NPORT), .DW(DW), .AW(AW)) icb_rr ();
    qpu_dtcm_mp_ctrl_if #(.NPORT(NPORT), .DW(DW), .AW(AW)) icb_fp ();

    logic          ram_cs, ram_we, clk_ram, active;
    logic [11:0]   ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din, ram_dout;

    logic          fp_cs, fp_we, fp_clk_ram, fp_active;
    logic [11:0]   fp_addr;
    logic [MW-1:0] fp_wem;
    logic [DW-1:0] fp_din;
    logic [DW-1:0] fp_dout = '0;

    qpu_dtcm_mp_ctrl #(.NPORT(NPORT), .DW(DW), .AW(AW), .DEPTH(DEPTH), .ARB_RR(1)) dut_rr (
        .clk(clk), .rst(rst), .tcm_cgstop(tcm_cgstop), .test_mode(test_mode), .icb(icb_rr),
        .dtcm_ram_cs(ram_cs), .dtcm_ram_we(ram_we), .dtcm_ram_addr(ram_addr),
        .dtcm_ram_wem(ram_wem), .dtcm_ram_din(ram_din), .dtcm_ram_dout(ram_dout),
        .clk_dtcm_ram(clk_ram), .dtcm_active(active)
    );

    qpu_dtcm_mp_ctrl #(.NPORT(NPORT), .DW(DW), .AW(AW), .DEPTH(DEPTH), .ARB_RR(0)) dut_fp (
        .clk(clk), .rst(rst), .tcm_cgstop(tcm_cgstop), .test_mode(test_mode), .icb(icb_fp),
        .dtcm_ram_cs(fp_cs), .dtcm_ram_we(fp_we), .dtcm_ram_addr(fp_addr),
        .dtcm_ram_wem(fp_wem), .dtcm_ram_din(fp_din), .dtcm_ram_dout(fp_dout),
        .clk_dtcm_ram(fp_clk_ram), .dtcm_active(fp_active)
    );

    // RAM model: 1-cycle read latency, dout scrambled whenever the RAM is idle.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < MW; b++)
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end else begin
            ram_dout <= $urandom;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rr(input int p, input logic v, input logic rd,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
        icb_rr.cmd_valid[p]            = v;
        icb_rr.cmd_read[p]             = rd;
        icb_rr.cmd_addr[p*AW +: AW]    = a;
        icb_rr.cmd_wdata[p*DW +: DW]   = wd;
        icb_rr.cmd_wmask[p*MW +: MW]   = '1;
    endtask

    task automatic set_fp(input int p, input logic v, input logic [AW-1:0] a);
        icb_fp.cmd_valid[p]            = v;
        icb_fp.cmd_read[p]             = 1'b0;
        icb_fp.cmd_addr[p*AW +: AW]    = a;
        icb_fp.cmd_wdata[p*DW +: DW]   = '0;
        icb_fp.cmd_wmask[p*MW +: MW]   = '1;
    endtask

    initial begin
        icb_rr.cmd_valid = '0; icb_rr.cmd_read = '0; icb_rr.cmd_addr = '0;
        icb_rr.cmd_wdata = '0; icb_rr.cmd_wmask = '0; icb_rr.rsp_ready = '1;
        icb_fp.cmd_valid = '0; icb_fp.cmd_read = '0; icb_fp.cmd_addr = '0;
        icb_fp.cmd_wdata = '0; icb_fp.cmd_wmask = '0; icb_fp.rsp_ready = '1;

        // Reset state
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(icb_rr.rsp_valid), 64'h0);
        check("rst_rsp_err",   64'(icb_rr.rsp_err),   64'h0);
        check("rst_rsp_rdata", 64'(icb_rr.rsp_rdata), 64'h0);
        check("rst_ram_cs",    64'(ram_cs),           64'h0);
        check("rst_ram_we",    64'(ram_we),           64'h0);
        check("rst_active",    64'(active),           64'h0);
        check("rst_fp_valid",  64'(icb_fp.rsp_valid), 64'h0);

        // Write then read back 0x10 on port 0
        @(negedge clk);
        set_rr(0, 1, 0, 16'h0010, 32'hDEADBEEF);
        #1;
        check("wr_cmd_ready", 64'(icb_rr.cmd_ready), 64'h1);
        check("wr_ram_cs",    64'(ram_cs),           64'h1);
        check("wr_ram_we",    64'(ram_we),           64'h1);
        check("wr_ram_addr",  64'(ram_addr),         64'h4);
        check("wr_ram_wem",   64'(ram_wem),          64'hF);
        check("wr_ram_din",   64'(ram_din),          64'hDEADBEEF);
        @(negedge clk);
        set_rr(0, 1, 1, 16'h0010, 32'h0);
        #1;
        check("wr_rsp_valid", 64'(icb_rr.rsp_valid), 64'h1);
        check("wr_rsp_rdata", 64'(icb_rr.rsp_rdata), 64'h0);
        check("rd_cmd_ready", 64'(icb_rr.cmd_ready), 64'h1);
        check("rd_ram_cs",    64'(ram_cs),           64'h1);
        check("rd_ram_we",    64'(ram_we),           64'h0);
        check("rd_ram_addr",  64'(ram_addr),         64'h4);
        check("rd_ram_wem",   64'(ram_wem),          64'h0);
        @(negedge clk);
        set_rr(0, 0, 0, 16'h0, 32'h0);
        #1;
        check("rd_rsp_valid", 64'(icb_rr.rsp_valid), 64'h1);
        check("rd_rsp_rdata", 64'(icb_rr.rsp_rdata), 64'hDEADBEEF);
        check("rd_rsp_err",   64'(icb_rr.rsp_err),   64'h0);
        check("rd_active",    64'(active),           64'h1);
        @(negedge clk);
        #1;
        check("idle_rsp_valid", 64'(icb_rr.rsp_valid), 64'h0);
        check("idle_active",    64'(active),           64'h0);

        // Round-robin with both ports valid; port 0 won last, so port 1 goes first
        @(negedge clk);
        set_rr(0, 1, 0, 16'h0040, 32'h000000A0);
        set_rr(1, 1, 0, 16'h0044, 32'h000000B1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("rr_cmd_ready", 64'(icb_rr.cmd_ready), (i % 2 == 0) ? 64'h2 : 64'h1);
            check("rr_ram_cs",    64'(ram_cs),           64'h1);
            check("rr_ram_din",   64'(ram_din),          (i % 2 == 0) ? 64'hB1 : 64'hA0);
            if (i > 0)
                check("rr_rsp_valid", 64'(icb_rr.rsp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        @(negedge clk);
        set_rr(0, 0, 0, 16'h0, 32'h0);
        set_rr(1, 0, 0, 16'h0, 32'h0);
        #1;
        check("rr_last_rsp", 64'(icb_rr.rsp_valid), 64'h1);

        // Fixed priority: port 0 always wins until it drops valid
        @(negedge clk);
        set_fp(0, 1, 16'h0040);
        set_fp(1, 1, 16'h0044);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("fp_cmd_ready", 64'(icb_fp.cmd_ready), 64'h1);
            check("fp_ram_cs",    64'(fp_cs),            64'h1);
        end
        @(negedge clk);
        set_fp(0, 0, 16'h0);
        #1;
        check("fp_p1_ready", 64'(icb_fp.cmd_ready), 64'h2);
        @(negedge clk);
        set_fp(1, 0, 16'h0);
        #1;
        check("fp_p1_rsp", 64'(icb_fp.rsp_valid), 64'h2);
        check("fp_rsp_err", 64'(icb_fp.rsp_err), 64'h0);

        // Read with response backpressure; held data must survive dout changes
        @(negedge clk);
        set_rr(0, 1, 0, 16'h0020, 32'h12345678);
        #1;
        check("hold_wr_ready", 64'(icb_rr.cmd_ready), 64'h1);
        @(negedge clk);
        set_rr(0, 1, 1, 16'h0020, 32'h0);
        #1;
        check("hold_rd_ready", 64'(icb_rr.cmd_ready), 64'h1);
        @(negedge clk);
        icb_rr.rsp_ready[0] = 1'b0;
        set_rr(1, 1, 0, 16'h0080, 32'h0);
        #1;
        check("hold_rsp_valid", 64'(icb_rr.rsp_valid), 64'h1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("hold_rdata",     64'(icb_rr.rsp_rdata), 64'h12345678);
            check("hold_cmd_ready", 64'(icb_rr.cmd_ready), 64'h0);
            check("hold_ram_cs",    64'(ram_cs),           64'h0);
        end
        icb_rr.rsp_ready[0] = 1'b1;
        #1;
        check("hold_release_ready", 64'(icb_rr.cmd_ready), 64'h2);
        @(negedge clk);
        set_rr(0, 0, 0, 16'h0, 32'h0);
        set_rr(1, 0, 0, 16'h0, 32'h0);
        #1;
        check("hold_next_rsp",   64'(icb_rr.rsp_valid), 64'h2);
        check("hold_next_rdata", 64'(icb_rr.rsp_rdata), 64'h0);

        // Out-of-range read: no RAM access, error response with zero data
        @(negedge clk);
        set_rr(0, 1, 1, 16'h4000, 32'h0);
        #1;
        check("oor_cmd_ready", 64'(icb_rr.cmd_ready), 64'h1);
        check("oor_ram_cs",    64'(ram_cs),           64'h0);
        @(negedge clk);
        set_rr(0, 0, 0, 16'h0, 32'h0);
        #1;
        check("oor_rsp_valid", 64'(icb_rr.rsp_valid), 64'h1);
        check("oor_rsp_err",   64'(icb_rr.rsp_err),   64'h1);
        check("oor_rsp_rdata", 64'(icb_rr.rsp_rdata), 64'h0);

        // Reset right after acceptance drops the response and re-centres the pointer
        @(negedge clk);
        set_rr(1, 1, 0, 16'h0050, 32'h55);
        #1;
        check("rstf_cmd_ready", 64'(icb_rr.cmd_ready), 64'h2);
        @(negedge clk);
        set_rr(1, 0, 0, 16'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("rstf_inflight", 64'(icb_rr.rsp_valid), 64'h2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstf_dropped", 64'(icb_rr.rsp_valid), 64'h0);
        set_rr(0, 1, 0, 16'h0060, 32'h66);
        set_rr(1, 1, 0, 16'h0064, 32'h77);
        #1;
        check("rstf_p0_first", 64'(icb_rr.cmd_ready), 64'h1);
        @(negedge clk);
        set_rr(0, 0, 0, 16'h0, 32'h0);
        set_rr(1, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
